// File: rtl/wb_shared_mem_responder.sv
// wb_shared_mem_responder
//   Wishbone responder for the shared RAM of the 4-core j1 cluster.
//   Eight requesters (data ports 0-3, fetch ports 4-7) share one
//   single-port synchronous RAM through a round-robin arbiter. One access
//   is in flight at a time: grant in IDLE, RAM access, one-cycle ack.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   m_cyc_i/m_we_i    data-port request / write enable per master
//   m_adr_i/m_dat_i   data-port word address / write data per master
//   m_ack_o/m_dat_o   data-port ack (one-hot) / broadcast read data
//   i_cyc_i/i_adr_i   fetch request / fetch word address per master
//   i_ack_o/i_dat_o   fetch ack (one-hot) / broadcast fetched word
//   busy_o            access in progress (ACCESS or ACK)
//   grant_o           index of the current or last granted requester
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample requests; on any request latch winner and go ACCESS
// ACCESS | latched address on RAM; write commits / read data registers
// ACK    | one ack bit for the granted requester; back to IDLE
module wb_shared_mem_responder #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int NM = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  output logic [NM-1:0]      m_ack_o,
  output logic [DW-1:0]      m_dat_o,
  input  logic [NM-1:0]      i_cyc_i,
  input  logic [NM*AW-1:0]   i_adr_i,
  output logic [NM-1:0]      i_ack_o,
  output logic [DW-1:0]      i_dat_o,
  output logic               busy_o,
  output logic [2:0]         grant_o
);

  localparam int NR = 2 * NM;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [NR-1:0]   w_req;
  logic            w_any;
  logic            w_grant_en;
  logic            w_found;
  logic [2:0]      w_idx;
  logic [2:0]      w_win;

  logic [2:0]      r_grant;
  logic [2:0]      r_ptr;
  logic [AW-1:0]   r_adr;
  logic            r_we;
  logic [DW-1:0]   r_wdat;
  logic [DW-1:0]   r_rdat;

  logic [AW-1:0]   w_adr;
  logic            w_we;
  logic [DW-1:0]   w_wdat;
  logic [NR-1:0]   w_ack;

  logic [DW-1:0]   r_mem [0:(1<<AW)-1];

  assign w_req      = {i_cyc_i, m_cyc_i};
  assign w_any      = |w_req;
  assign w_grant_en = (r_state == ST_IDLE) && w_any;

  // Scan upward from the pointer; the 3-bit sum wraps 7 -> 0 naturally.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NR; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Fetch ports are read-only, so their we/data stay at the defaults.
  always_comb begin
    w_adr  = '0;
    w_we   = 1'b0;
    w_wdat = '0;
    for (int k = 0; k < NM; k++) begin
      if (w_win == 3'(k)) begin
        w_adr  = m_adr_i[k*AW +: AW];
        w_we   = m_we_i[k];
        w_wdat = m_dat_i[k*DW +: DW];
      end
      if (w_win == 3'(k + NM)) begin
        w_adr = i_adr_i[k*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_wdat  <= '0;
      r_rdat  <= '0;
    end else begin
      if (w_grant_en) begin
        r_grant <= w_win;
        r_ptr   <= w_win + 3'd1;
        r_adr   <= w_adr;
        r_we    <= w_we;
        r_wdat  <= w_wdat;
      end
      // Read-before-write: a write access returns the old word.
      if (r_state == ST_ACCESS) begin
        r_rdat <= r_mem[r_adr];
      end
    end
  end

  // No reset on the array; an async reset during ACCESS forces IDLE
  // before the edge, which suppresses the write.
  always_ff @(posedge clk) begin
    if (r_state == ST_ACCESS && r_we) begin
      r_mem[r_adr] <= r_wdat;
    end
  end

  always_comb begin
    w_ack = '0;
    if (r_state == ST_ACK) begin
      w_ack[r_grant] = 1'b1;
    end
  end

  assign m_ack_o = w_ack[NM-1:0];
  assign i_ack_o = w_ack[NR-1:NM];
  assign m_dat_o = r_rdat;
  assign i_dat_o = r_rdat;
  assign busy_o  = (r_state != ST_IDLE);
  assign grant_o = r_grant;

endmodule
